// File: rtl/core_pkg.sv
// Shared constants, opcodes and FSM encoding for the
// instruction sequencer and its byte serializer.
package core_pkg;

  localparam int C_OPW = 4;
  localparam int C_DW  = 16;
  localparam int C_BW  = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_PASS = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WB,
    S_OUT_HI,
    S_OUT_LO
  } state_t;

  function automatic logic is_alu_op(
    input logic [3:0] op
  );
    return (op >= OP_ADD) && (op <= OP_PASS);
  endfunction

  function automatic logic is_legal(
    input logic [3:0] op
  );
    return (op <= OP_PASS) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-in and byte-out valid/ready
// handshakes of the sequencer.
interface core_sequencer_if
  import core_pkg::*;
#(
  parameter int OPW = C_OPW,
  parameter int DW  = C_DW,
  parameter int BW  = C_BW
);

  logic                instr_valid;
  logic                instr_ready;
  logic [OPW+DW-1:0]   instr_data;
  logic [BW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output instr_valid,
    output instr_data,
    output out_ready,
    input  instr_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    input  out_ready,
    output instr_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/byte_serializer.sv
// Captures a word on start and emits it as two
// bytes, high first, over a valid/ready port.
module byte_serializer
  import core_pkg::*;
#(
  parameter int DW = C_DW,
  parameter int BW = C_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] data_in,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
);

  logic [DW-1:0] shadow;
  logic          hi;
  logic          lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else if (start) begin
      shadow <= data_in;
      hi     <= 1'b1;
      lo     <= 1'b0;
    end else if (hi && out_ready) begin
      hi <= 1'b0;
      lo <= 1'b1;
    end else if (lo && out_ready) begin
      lo <= 1'b0;
    end
  end

  always_comb begin
    out_data = '0;
    if (hi)
      out_data = shadow[DW-1:BW];
    else if (lo)
      out_data = shadow[BW-1:0];
  end

  assign out_valid = hi | lo;
  assign done      = lo & out_ready;

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: decodes opcodes into
// register strobes, ALU op and byte output.
module core_sequencer
  import core_pkg::*;
#(
  parameter int OPW = C_OPW,
  parameter int DW  = C_DW,
  parameter int BW  = C_BW
) (
  input  logic           clk,
  input  logic           rst,
  core_sequencer_if.slave bus,
  output logic [DW-1:0]  operand_out,
  output logic [OPW-1:0] alu_op,
  output logic           load_a,
  output logic           load_b,
  output logic           load_c,
  input  logic [DW-1:0]  reg_c_in,
  output logic           busy,
  output logic           illegal_op,
  output logic [15:0]    op_count
);

  state_t state;
  state_t state_n;
  logic   start;
  logic   done;
  logic   cnt_inc;

  byte_serializer #(
    .DW(DW),
    .BW(BW)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (reg_c_in),
    .out_data (bus.out_data),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .done     (done)
  );

  assign bus.instr_ready = (state == S_IDLE);
  assign busy            = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      alu_op      <= '0;
      operand_out <= '0;
      op_count    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.instr_valid) begin
        alu_op      <= bus.instr_data[OPW+DW-1:DW];
        operand_out <= bus.instr_data[DW-1:0];
      end
      if (cnt_inc)
        op_count <= op_count + 16'd1;
    end
  end

  always_comb begin
    state_n    = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_c     = 1'b0;
    illegal_op = 1'b0;
    start      = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.instr_valid)
          state_n = S_DISPATCH;
      end
      S_DISPATCH: begin
        state_n = S_IDLE;
        unique case (1'b1)
          (alu_op == OP_NOP): cnt_inc = 1'b1;
          (alu_op == OP_LDA): begin
            load_a  = 1'b1;
            cnt_inc = 1'b1;
          end
          (alu_op == OP_LDB): begin
            load_b  = 1'b1;
            cnt_inc = 1'b1;
          end
          is_alu_op(alu_op): state_n = S_WB;
          (alu_op == OP_OUT): begin
            start   = 1'b1;
            state_n = S_OUT_HI;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      S_WB: begin
        load_c  = 1'b1;
        cnt_inc = 1'b1;
        state_n = S_IDLE;
      end
      S_OUT_HI: begin
        if (bus.out_ready)
          state_n = S_OUT_LO;
      end
      S_OUT_LO: begin
        if (done) begin
          cnt_inc = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a
// strobe/byte scoreboard.
module tb_core_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] operand_out;
  logic [3:0]  alu_op;
  logic        load_a;
  logic        load_b;
  logic        load_c;
  logic [15:0] reg_c_in;
  logic        busy;
  logic        illegal_op;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] val;
    int          at;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] byte_q[$];

  core_sequencer_if #(.OPW(4), .DW(16), .BW(8)) bus ();

  core_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .operand_out(operand_out),
    .alu_op     (alu_op),
    .load_a     (load_a),
    .load_b     (load_b),
    .load_c     (load_c),
    .reg_c_in   (reg_c_in),
    .busy       (busy),
    .illegal_op (illegal_op),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] s;
    ev_t        e;
    logic [7:0] b;
    #2;
    if (!rst) begin
      s = {load_a, load_b, load_c, illegal_op};
      check("strobe_excl", 32'($countones(s) <= 1), 32'd1);
      if (s != 4'd0) begin
        if (ev_q.size() == 0) begin
          check("strobe_unexpected", 32'(s), 32'd0);
        end else begin
          e = ev_q.pop_front();
          check("strobe_code", 32'(s), 32'(e.code));
          check("strobe_cycle", 32'(cyc), 32'(e.at));
          if (load_a || load_b)
            check("strobe_operand", 32'(operand_out), 32'(e.val));
          if (load_c)
            check("strobe_alu_op", 32'(alu_op), 32'(e.val));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (byte_q.size() == 0) begin
          check("byte_unexpected", 32'(bus.out_data), 32'hFFFF);
        end else begin
          b = byte_q.pop_front();
          check("out_byte", 32'(bus.out_data), 32'(b));
        end
      end
    end
  end

  task automatic send(input logic [19:0] w);
    logic [3:0] op;
    int         n;
    bit         ok;
    ev_t        e;
    op = w[19:16];
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    @(posedge clk);
    #1;
    n = cyc;
    e.val = w[15:0];
    e.at  = n;
    e.code = 4'd0;
    if (op == 4'h1) e.code = 4'b1000;
    else if (op == 4'h2) e.code = 4'b0100;
    else if (op >= 4'h3 && op <= 4'h8) begin
      e.code = 4'b0010;
      e.val  = {12'd0, op};
      e.at   = n + 1;
    end else if (op >= 4'h9 && op <= 4'hE)
      e.code = 4'b0001;
    if (e.code != 4'd0) ev_q.push_back(e);
    if (op == 4'hF) begin
      byte_q.push_back(reg_c_in[15:8]);
      byte_q.push_back(reg_c_in[7:0]);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.out_ready   = 1'b1;
    reg_c_in        = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_operand", 32'(operand_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(20'h1_1234);
    check("lda_ready_low", 32'(bus.instr_ready), 32'd0);
    check("lda_busy", 32'(busy), 32'd1);
    check("lda_operand", 32'(operand_out), 32'h1234);
    @(negedge clk);
    check("lda_count", 32'(op_count), 32'd1);
    check("lda_ready_back", 32'(bus.instr_ready), 32'd1);

    send(20'h1_0005);
    send(20'h2_0003);
    send(20'h3_0000);
    check("add_alu_op", 32'(alu_op), 32'h3);
    @(negedge clk);
    check("wb_alu_op", 32'(alu_op), 32'h3);
    check("wb_ready_low", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    check("add_count", 32'(op_count), 32'd4);
    check("add_alu_hold", 32'(alu_op), 32'h3);

    reg_c_in      = 16'hABCD;
    bus.out_ready = 1'b0;
    send(20'hF_0000);
    check("out_disp_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("out_hi_valid", 32'(bus.out_valid), 32'd1);
      check("out_hi_stable", 32'(bus.out_data), 32'hAB);
    end
    reg_c_in      = 16'h0000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("out_lo_data", 32'(bus.out_data), 32'hCD);
    @(negedge clk);
    check("out_idle_busy", 32'(busy), 32'd0);
    check("out_idle_valid", 32'(bus.out_valid), 32'd0);
    check("out_count", 32'(op_count), 32'd5);

    send(20'hA_FFFF);
    @(negedge clk);
    check("ill_ready", 32'(bus.instr_ready), 32'd1);
    check("ill_count", 32'(op_count), 32'd5);

    reg_c_in      = 16'h1357;
    bus.out_ready = 1'b0;
    send(20'hF_0000);
    @(negedge clk);
    check("rst_mid_hi_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    byte_q.delete();
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_count", 32'(op_count), 32'd0);
    check("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send(20'h1_0042);
    check("post_rst_operand", 32'(operand_out), 32'h0042);
    @(negedge clk);
    check("post_rst_count", 32'(op_count), 32'd1);

    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    @(negedge clk);
    check("wrap_preload", 32'(op_count), 32'hFFFF);
    send(20'h0_0000);
    @(negedge clk);
    check("wrap_count", 32'(op_count), 32'd0);

    repeat (3) @(negedge clk);
    check("ev_q_empty", 32'(ev_q.size()), 32'd0);
    check("byte_q_empty", 32'(byte_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
